// File: rtl/bus_arb_pkg.sv
// Shared encodings for the client rq/ack bus: responder states, wr_ni polarity,
// statistics counter width and an index-width helper for windowed arrays.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic WRITE      = 1'b1;
    localparam logic READ       = 1'b0;
    localparam int   STAT_WIDTH = 16;
    localparam int   WAIT_WIDTH = 4;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Storage behind one responder window: synchronous write, registered read.
// Latency: read data valid one cycle after re; zero whenever re was low.
// Backpressure: none, the controlling FSM issues at most one access per cycle.
module mem_responder_array
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdat,
    output logic [DATA_WIDTH-1:0] rdat
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Contents intentionally survive reset; only the read port is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdat;
        end
    end

    // Clearing on non-read cycles keeps rdat OR-combinable on a shared bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdat <= '0;
        end else begin
            rdat <= re ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Target side of the rq/ack handshake for one address window; optional counters via MEM_RESPONDER_STATS_EN.
// Latency: ack pulses WAIT_STATES edges after rq is first sampled (WAIT_STATES+1 cycles to end of ack).
// Backpressure: initiator holds rq; dropping it during wait states aborts, holding it past ack is not re-serviced.
module mem_responder
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int ADDR_BASE   = 0,
    parameter int ADDR_LIMIT  = 3,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rq,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dataR
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] rd_count,
    output logic [STAT_WIDTH-1:0] wr_count
`endif
);

    localparam int DEPTH = ADDR_LIMIT - ADDR_BASE + 1;
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(ADDR_LIMIT - ADDR_BASE);
    localparam logic [WAIT_WIDTH-1:0] WAIT_INIT = WAIT_WIDTH'(WAIT_STATES);

    state_t                  state, state_nxt;
    logic [WAIT_WIDTH-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [ADDR_WIDTH:0]     diff;
    logic                    in_win;
    logic                    commit;
    logic [IDX_W-1:0]        acc_idx;
    logic                    acc_wr;
    logic [DATA_WIDTH-1:0]   acc_dat;

    // Borrow-out of the subtraction is the below-base test, so no wrap-around.
    assign diff   = {1'b0, address} - {1'b0, BASE};
    assign in_win = rq && !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] <= SPAN);

    // With zero wait states ACK is entered from IDLE, before the latches hold the request.
    assign acc_idx = (state == IDLE) ? diff[IDX_W-1:0] : idx_q;
    assign acc_wr  = (state == IDLE) ? wr_ni : wr_q;
    assign acc_dat = (state == IDLE) ? dataW : dat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (in_win) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!rq) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == WAIT_WIDTH'(1)) begin
                    state_nxt = ACK;
                    commit    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - WAIT_WIDTH'(1);
                end
            end
            ACK:     state_nxt = rq ? RELEASE : IDLE;
            RELEASE: state_nxt = rq ? RELEASE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            wr_q  <= READ;
            dat_q <= '0;
            ack   <= 1'b0;
        end else begin
            if (state == IDLE && in_win) begin
                idx_q <= diff[IDX_W-1:0];
                wr_q  <= wr_ni;
                dat_q <= dataW;
            end
            ack <= commit;
        end
    end

    mem_responder_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit && acc_wr == WRITE),
        .re    (commit && acc_wr == READ),
        .idx   (acc_idx),
        .wdat  (acc_dat),
        .rdat  (dataR)
    );

`ifdef MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (commit) begin
            if (acc_wr == WRITE && wr_count != '1) begin
                wr_count <= wr_count + STAT_WIDTH'(1);
            end
            if (acc_wr == READ && rd_count != '1) begin
                rd_count <= rd_count + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Two responders share one bus: window 0..3 with two wait states, window 4..7 with none.
// Requests queue their expected ack (cycle, responder, data); a monitor pops and compares.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rq = 1'b0;
    logic       wr_ni = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] dataW = '0;
    logic       ack_a, ack_b;
    logic [7:0] dataR_a, dataR_b;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rd_a, wr_a, rd_b, wr_b;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    mem_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_BASE(0), .ADDR_LIMIT(3), .WAIT_STATES(2)
    ) u_a (
        .clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni),
        .dataW(dataW), .ack(ack_a), .dataR(dataR_a)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count(rd_a), .wr_count(wr_a)
`endif
    );

    mem_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_BASE(4), .ADDR_LIMIT(7), .WAIT_STATES(0)
    ) u_b (
        .clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni),
        .dataW(dataW), .ack(ack_b), .dataR(dataR_b)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count(rd_b), .wr_count(wr_b)
`endif
    );

    typedef struct {
        int         cyc;
        int         inst;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mdl [0:7];
    int         m_rd [0:1];
    int         m_wr [0:1];
    bit         done = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Must be called just after a rising edge. rq is sampled high on n edges, then low on gap edges.
    task automatic req(input logic [3:0] a, input logic w, input logic [7:0] d,
                       input int n, input int gap);
        int   inst;
        int   ws;
        exp_t e;
        address = a;
        wr_ni   = w;
        dataW   = d;
        rq      = 1'b1;
        if (a < 4'd8) begin
            inst = (a < 4'd4) ? 0 : 1;
            ws   = (inst == 0) ? 2 : 0;
            if (n >= ws + 1) begin
                e.cyc  = cyc + 1 + ws;
                e.inst = inst;
                e.dat  = w ? 8'h00 : mdl[a[2:0]];
                if (w) begin
                    mdl[a[2:0]] = d;
                    m_wr[inst]++;
                end else begin
                    m_rd[inst]++;
                end
                exp_q.push_back(e);
            end
        end
        repeat (n) @(posedge clk);
        #1;
        rq      = 1'b0;
        address = 4'($urandom);
        wr_ni   = 1'($urandom);
        dataW   = 8'($urandom);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    initial begin
        m_rd = '{0, 0};
        m_wr = '{0, 0};
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) req(4'(i), 1'b1, 8'(8'h10 + i), 3, 1);
        req(4'd2, 1'b1, 8'hA5, 3, 1);
        req(4'd2, 1'b0, 8'h00, 3, 1);
        req(4'd4, 1'b0, 8'h00, 10, 1);
        req(4'd9, 1'b0, 8'h00, 10, 1);
        req(4'd1, 1'b1, 8'h3C, 2, 1);
        req(4'd1, 1'b0, 8'h00, 3, 1);
        req(4'd2, 1'b0, 8'h00, 11, 1);
        // Reset lands while the write to address 1 is waiting.
        address = 4'd1;
        wr_ni   = 1'b1;
        dataW   = 8'hEE;
        rq      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rq    = 1'b0;
        m_rd  = '{0, 0};
        m_wr  = '{0, 0};
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        req(4'd1, 1'b0, 8'h00, 3, 1);
        req(4'd5, 1'b1, 8'h5A, 1, 1);
        req(4'd5, 1'b0, 8'h00, 1, 1);
        req(4'd6, 1'b0, 8'h00, 1, 1);
        repeat (300) begin
            logic [3:0] a;
            a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            req(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 8), $urandom_range(1, 3));
        end
        repeat (4) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        exp_t       e;
        int         got_inst;
        logic [7:0] got_dat;
        while (!done) begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (ack_a || ack_b || dataR_a != 8'h00 || dataR_b != 8'h00) begin
                    failures++;
                    $display("FAIL reset_outputs cyc=%0d ack=%b%b dataR=%02h/%02h required all zero",
                             cyc, ack_a, ack_b, dataR_a, dataR_b);
                end
`ifdef MEM_RESPONDER_STATS_EN
                checks++;
                if (rd_a != 16'd0 || wr_a != 16'd0 || rd_b != 16'd0 || wr_b != 16'd0) begin
                    failures++;
                    $display("FAIL reset_counts cyc=%0d got %0d/%0d/%0d/%0d required 0",
                             cyc, rd_a, wr_a, rd_b, wr_b);
                end
`endif
            end else begin
                checks++;
                if ((!ack_a && dataR_a != 8'h00) || (!ack_b && dataR_b != 8'h00)) begin
                    failures++;
                    $display("FAIL dataR_idle cyc=%0d dataR=%02h/%02h required 00 outside ack",
                             cyc, dataR_a, dataR_b);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_ack cyc=%0d expected ack at cyc=%0d inst=%0d",
                             cyc, exp_q[0].cyc, exp_q[0].inst);
                    void'(exp_q.pop_front());
                end
                if (ack_a || ack_b) begin
                    checks++;
                    got_inst = ack_a ? 0 : 1;
                    got_dat  = ack_a ? dataR_a : dataR_b;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_ack cyc=%0d inst=%0d data=%02h required no ack",
                                 cyc, got_inst, got_dat);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.inst != got_inst || e.dat != got_dat || (ack_a && ack_b)) begin
                            failures++;
                            $display("FAIL ack_response got cyc=%0d inst=%0d data=%02h both=%b required cyc=%0d inst=%0d data=%02h",
                                     cyc, got_inst, got_dat, ack_a && ack_b, e.cyc, e.inst, e.dat);
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_acks got %0d outstanding required 0", exp_q.size());
        end
`ifdef MEM_RESPONDER_STATS_EN
        checks++;
        if (int'(rd_a) != m_rd[0] || int'(wr_a) != m_wr[0] ||
            int'(rd_b) != m_rd[1] || int'(wr_b) != m_wr[1]) begin
            failures++;
            $display("FAIL stat_counts got rd/wr a=%0d/%0d b=%0d/%0d required a=%0d/%0d b=%0d/%0d",
                     rd_a, wr_a, rd_b, wr_b, m_rd[0], m_wr[0], m_rd[1], m_wr[1]);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
